// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its word array.
package mem_responder_pkg;

  localparam int unsigned MEM_ADDR_W = 14;
  localparam int unsigned MEM_DATA_W = 16;

  localparam logic [MEM_DATA_W-1:0] MEM_ERR_DATA = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RELEASE
  } memresp_state_t;

  typedef enum logic [1:0] {
    MOP_READ,
    MOP_WRITE,
    MOP_ERR
  } memop_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Four-phase memory bus between an initiator (master) and the responder (slave).
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);

  logic              cs;
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_resp;
  logic              err;

  modport master (
    output cs, read_req, write_req, addr, wdata,
    input  rdata, mem_resp, err
  );

  modport slave (
    input  cs, read_req, write_req, addr, wdata,
    output rdata, mem_resp, err
  );

endinterface

// File: rtl/mem_responder_sram.sv
// Single-port synchronous word array; one-cycle read, no reset on contents.
module mem_responder_sram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= din;
      end else begin
        dout <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, services it after LATENCY cycles,
// pulses mem_resp and waits for cs to drop before accepting the next one.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  output logic [15:0]          rd_cnt,
  output logic [15:0]          wr_cnt
);

  localparam int unsigned SramAw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LatLoad = 4'(LATENCY);

  memresp_state_t    state_q;
  memop_t            op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic              mem_resp_q;
  logic              err_q;
  logic              rdata_from_mem_q;
  logic [15:0]       rd_cnt_q;
  logic [15:0]       wr_cnt_q;

  logic              accept;
  memop_t            bus_op;
  memop_t            cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              fire;
  logic              good;
  logic              sram_en;
  logic              sram_we;
  logic [DATA_W-1:0] sram_dout;

  // In IDLE the bus fields are used directly so LATENCY=0 can complete at acceptance.
  always_comb begin
    accept    = (state_q == IDLE) && bus.cs && (bus.read_req || bus.write_req);
    bus_op    = (bus.read_req && bus.write_req) ? MOP_ERR :
                (bus.write_req ? MOP_WRITE : MOP_READ);
    cur_op    = (state_q == IDLE) ? bus_op : op_q;
    cur_addr  = (state_q == IDLE) ? bus.addr : addr_q;
    cur_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
    fire      = (LATENCY == 0) ? accept : ((state_q == BUSY) && (cnt_q == 4'd1));
    good      = (32'(cur_addr) < DEPTH) && (cur_op != MOP_ERR);
    sram_en   = fire && good && !reset;
    sram_we   = (cur_op == MOP_WRITE);
  end

  mem_responder_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (SramAw)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (cur_addr[SramAw-1:0]),
    .din  (cur_wdata),
    .dout (sram_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      op_q             <= MOP_READ;
      addr_q           <= '0;
      wdata_q          <= '0;
      cnt_q            <= 4'd0;
      mem_resp_q       <= 1'b0;
      err_q            <= 1'b0;
      rdata_from_mem_q <= 1'b0;
      rd_cnt_q         <= 16'd0;
      wr_cnt_q         <= 16'd0;
    end else begin
      mem_resp_q <= fire;
      err_q      <= fire && !good;

      if (fire && good) begin
        if (cur_op == MOP_READ) rd_cnt_q <= sat_inc16(rd_cnt_q);
        if (cur_op == MOP_WRITE) wr_cnt_q <= sat_inc16(wr_cnt_q);
      end

      // rdata follows the array after a good read; failed reads and error ops force zero.
      if (fire && (cur_op != MOP_WRITE)) begin
        rdata_from_mem_q <= good;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus_op;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= LatLoad;
            state_q <= (LATENCY == 0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP:    state_q <= RELEASE;
        RELEASE: if (!bus.cs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata    = rdata_from_mem_q ? sram_dout : MEM_ERR_DATA;
  assign bus.mem_resp = mem_resp_q;
  assign bus.err      = err_q;
  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;

endmodule
